// File: rtl/fetch_redirect.sv
// fetch_redirect: fetch PC register plus the decode-stage prediction record.
// Resolves conditional branches in decode against the prediction that fetched
// them and redirects the fetch PC one cycle after a misprediction.
// Optional macro BRANCH_STATS_EN builds saturating branch / misprediction
// counters; without it both counter ports are tied to zero.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pred_taken,
    input  logic [31:0] PC_pred,
    input  logic        branchD,
    input  logic        pcsrcD,
    input  logic [31:0] PCBranchD,
    output logic [31:0] PC,
    output logic        mispredictD,
    output logic        flushD,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic [31:0] pc_q, pc_d;
    logic        vd_q, vd_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic [31:0] pcplus4;
    logic [31:0] recovery;
    logic        resolve;
    logic        mismatch;

    assign pcplus4 = pc_q + 32'd4;
    // A record only resolves when it is valid and decode is advancing.
    assign resolve = vd_q & ~stallD;

    // Compare the carried prediction with the decode resolution
    always_comb begin
        mismatch = 1'b0;
        if (resolve) begin
            if (branchD && !taken_q && pcsrcD) begin
                mismatch = 1'b1;
            end else if (taken_q && !pcsrcD) begin
                mismatch = 1'b1;
            end else if (taken_q && pcsrcD && (target_q != PCBranchD)) begin
                mismatch = 1'b1;
            end else if (!branchD && taken_q) begin
                // Predictor aliased a non-branch as taken.
                mismatch = 1'b1;
            end
        end
        recovery = (branchD && pcsrcD) ? PCBranchD : pcplus4_q;
    end

    // Next fetch PC and next decode record
    always_comb begin
        pc_d      = pc_q;
        vd_d      = vd_q;
        taken_d   = taken_q;
        target_d  = target_q;
        pcplus4_d = pcplus4_q;

        if (mismatch) begin
            pc_d = recovery;
        end else if (stallF) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = PC_pred;
        end else begin
            pc_d = pcplus4;
        end

        if (mismatch) begin
            // Flushed slot must never resolve.
            vd_d = 1'b0;
        end else if (stallD) begin
            vd_d = vd_q;
        end else if (stallF) begin
            vd_d = 1'b0;
        end else begin
            vd_d      = 1'b1;
            taken_d   = pred_taken;
            target_d  = PC_pred;
            pcplus4_d = pcplus4;
        end
    end

    // PC and decode record state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            vd_q      <= 1'b0;
            taken_q   <= 1'b0;
            target_q  <= 32'h0;
            pcplus4_q <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            vd_q      <= vd_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign PC          = pc_q;
    assign mispredictD = mismatch;
    assign flushD      = mismatch;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Saturating branch and misprediction counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= 32'h0;
            mispred_cnt_q <= 32'h0;
        end else begin
            if (resolve && branchD && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mismatch && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
`else
    assign branch_count     = 32'h0;
    assign mispredict_count = 32'h0;
`endif

endmodule
